// File: rtl/comb_scheduler.sv
// comb_scheduler
//   Accepts combination jobs C(N,M) from two requesters, queues them in a
//   DEPTH-entry FIFO and runs them one at a time on an external combination
//   engine. A watchdog aborts a job whose engine never reports done.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   reqX_valid/ready, reqX_n/m    job offer handshake and operands (X = 0, 1)
//   eng_start, eng_n, eng_m       one-cycle start pulse and operands to engine
//   eng_done, eng_out             engine completion and 13-bit result
//   res_valid/ready               result handshake
//   res_id, res_value, res_err    originating requester, result, timeout flag
//   busy                          FSM active or jobs queued
module comb_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_n,
  input  logic [3:0]  req0_m,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_n,
  input  logic [3:0]  req1_m,
  output logic        eng_start,
  output logic [3:0]  eng_n,
  output logic [3:0]  eng_m,
  input  logic        eng_done,
  input  logic [12:0] eng_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [12:0] res_value,
  output logic        res_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic       id;
    logic [3:0] n;
    logic [3:0] m;
  } job_t;

  job_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty;
  logic          rr;        // 0: req0 wins a tie, 1: req1 wins a tie
  logic          gnt1;
  logic          push, pop;
  job_t          push_job, head;

  logic [1:0]    state;
  job_t          job;
  logic [CW-1:0] cnt;

  // Extra pointer bit distinguishes full from empty.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign gnt1 = req1_valid && (!req0_valid || rr);

  // Full is taken from registered pointers only, so a pop in the same cycle
  // never opens a slot. Ready is gated by rst so it is 0 during reset.
  assign req0_ready = rst && !full && req0_valid && !gnt1;
  assign req1_ready = rst && !full && gnt1;

  assign push     = req0_ready || req1_ready;
  assign push_job = gnt1 ? job_t'({1'b1, req1_n, req1_m})
                         : job_t'({1'b0, req0_n, req0_m});
  assign pop      = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_job;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= ~rr;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      job       <= '0;
      cnt       <= '0;
      res_id    <= 1'b0;
      res_value <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          job    <= head;
          res_id <= head.id;
          // M > N gives C(N,M) = 0 without involving the engine.
          if (head.m > head.n) begin
            res_value <= '0;
            res_err   <= 1'b0;
            state     <= S_RESP;
          end else begin
            state <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            res_value <= eng_out;
            res_err   <= 1'b0;
            state     <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_value <= '0;
            res_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded from the async-reset state register, so these drop as soon as
  // rst falls.
  assign eng_start = (state == S_START);
  assign eng_n     = (state == S_START || state == S_WAIT) ? job.n : 4'd0;
  assign eng_m     = (state == S_START || state == S_WAIT) ? job.m : 4'd0;
  assign res_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || !empty;

endmodule

// File: doc/comb_scheduler.md
COMB_SCHEDULER -- requirements
Module: comb_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, job FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 4095, max WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 offers a job.
REQ-006 req0_ready / req1_ready  output  1  job accepted on the edge where valid&ready.
REQ-007 req0_n, req0_m / req1_n, req1_m  input  4 each  job operands N, M.
REQ-008 eng_start  output  1  one-cycle start pulse to combination engine.
REQ-009 eng_n, eng_m  output  4 each  operands to engine, stable from start through done.
REQ-010 eng_done  input  1  engine completion.
REQ-011 eng_out  input  13  engine result C(N,M).
REQ-012 res_valid  output  1  result available; res_ready  input  1  consumer accepts.
REQ-013 res_id  output  1  originating requester; res_value  output  13  result; res_err  output  1  timeout flag.
REQ-014 busy  output  1  high when state != IDLE or FIFO non-empty.

Function
REQ-015 Arbitration: grant = sole valid requester; both valid -> requester selected by rr pointer; rr pointer toggles after each accepted job.
REQ-016 reqX_ready SHALL be high only when FIFO not full and X is granted; at most one ready per cycle.
REQ-017 FIFO full: both ready low; a same-cycle pop SHALL NOT enable a push.
REQ-018 FIFO entry = {id, N, M}, 9 bits, strict first-in-first-out order.
REQ-019 FSM states: IDLE, START, WAIT, RESP.
REQ-020 IDLE: FIFO non-empty -> pop head into job registers; M>N -> RESP with value 0, err 0, no eng_start; else -> START.
REQ-021 START: eng_start=1 for exactly one cycle, watchdog counter cleared -> WAIT.
REQ-022 WAIT: eng_done=1 -> capture eng_out into res_value, err 0 -> RESP; else counter+1; counter reaching TIMEOUT -> RESP, value 0, err 1.
REQ-023 RESP: res_valid=1, res_id/res_value/res_err held until res_valid&res_ready edge -> IDLE.
REQ-024 eng_done outside WAIT SHALL be ignored.
REQ-025 Latency: job accepted at edge t into empty FIFO with FSM in IDLE -> pop at edge t+1, eng_start high in cycle after edge t+1, RESP entered edge after eng_done sampled.
REQ-026 eng_n/eng_m SHALL equal popped job operands from START until leaving WAIT; 0 otherwise.
REQ-027 FIFO continues accepting jobs in any FSM state while not full.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, FIFO empty, rr pointer favouring req0, counter 0, all outputs 0.
REQ-029 Reset mid-job SHALL abandon the job and queued jobs with no result; eng_start drops asynchronously.

Verification
REQ-030 req0 N=5,M=2; engine returns 10 after 20 cycles -> one eng_start pulse, res_valid, res_id=0, res_value=10, res_err=0.
REQ-031 req1 N=3,M=5 -> no eng_start, res_value=0, res_err=0, res_id=1.
REQ-032 req0 (12,6) and req1 (4,2) valid same cycle after reset -> req0 accepted first; results 924 (id 0) then 6 (id 1).
REQ-033 res_ready held low, 5 jobs offered with DEPTH=4 -> one job in RESP, 4 queued, ready low; results drain in order once res_ready=1.
REQ-034 eng_done never asserted, TIMEOUT=15 -> RESP after 15 WAIT cycles, res_err=1, res_value=0.
REQ-035 rst low during WAIT -> all outputs 0 same cycle; after release busy=0 and no stale result.
